// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-cache main-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to whoever did not win last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output req_id_t    winner
);

  always_comb begin
    winner = last;
    unique case (req)
      2'b01:   winner = REQ_I;
      2'b10:   winner = REQ_D;
      2'b11:   winner = other_req(last);
      default: winner = last;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache block traffic onto one main-memory port.
// Grants run to completion; ties alternate between the two caches.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  arb_state_t        r_state;
  req_id_t           r_last;
  logic              r_first;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_writedata;

  logic    w_i_req;
  logic    w_d_req;
  logic    w_done;
  req_id_t w_winner;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  rr_pick2 u_pick (
    .req    ({w_d_req, w_i_req}),
    .last   (r_last),
    .winner (w_winner)
  );

  // Completion cycle: past the grant's first cycle with memory ready; reset cancels it.
  assign w_done = reset && !r_first && !mem_busywait;

  assign i_busywait = w_i_req && !(w_done && (r_state == GRANT_I));
  assign d_busywait = w_d_req && !(w_done && (r_state == GRANT_D));

  assign i_readdata = mem_readdata;
  assign d_readdata = mem_readdata;

  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_last          <= REQ_I;
      r_first         <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_i_req || w_d_req) begin
            r_last  <= w_winner;
            r_first <= 1'b1;
            if (w_winner == REQ_D) begin
              r_state         <= GRANT_D;
              r_mem_address   <= d_address;
              r_mem_writedata <= d_writedata;
              // A write-back takes priority over a simultaneous read request.
              r_mem_write     <= d_write;
              r_mem_read      <= d_read & ~d_write;
            end else begin
              r_state         <= GRANT_I;
              r_mem_address   <= i_address;
              r_mem_writedata <= '0;
              r_mem_write     <= 1'b0;
              r_mem_read      <= 1'b1;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (r_first) begin
            r_first <= 1'b0;
          end else if (!mem_busywait) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_first     <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, grant scoreboard, vector table and corner sequences.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 6;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_writedata;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_readdata    (i_readdata),
    .i_busywait    (i_busywait),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] a;
    bit            rd;
    bit            wr;
    logic [DW-1:0] wd;
  } grant_t;

  typedef struct {
    bit            ir;
    logic [AW-1:0] ia;
    bit            dr;
    bit            dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dwd;
    int            lat;
    bit            d_first;
    bit            exp_drd;
    bit            exp_dwr;
  } vec_t;

  grant_t        exp_q[$];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] mem_arr [64];
  int            lat = 2;
  int            cnt = 0;

  function automatic logic [DW-1:0] pattern(input int a);
    logic [31:0] w;
    w = a;
    return {32'hA5A5_0000 | w, 32'h5A5A_0000 | w, 32'hC3C3_0000 | w, 32'h3C3C_0000 | w};
  endfunction

  function automatic grant_t mkg(input logic [AW-1:0] a, input bit rd, input bit wr,
                                 input logic [DW-1:0] wd);
    grant_t g;
    g.a = a; g.rd = rd; g.wr = wr; g.wd = wd;
    return g;
  endfunction

  function automatic vec_t mkv(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                               input logic [AW-1:0] da, input logic [DW-1:0] dwd, input int l,
                               input bit dfirst, input bit edrd, input bit edwr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.lat = l; v.d_first = dfirst; v.exp_drd = edrd; v.exp_dwr = edwr;
    return v;
  endfunction

  // Main memory: busy for lat cycles after a strobe, write lands at the completion edge.
  assign mem_busywait = (mem_read | mem_write) && (cnt < lat);
  assign mem_readdata = mem_arr[mem_address];

  initial begin
    for (int k = 0; k < 64; k++) mem_arr[k] <= pattern(k);
    forever begin
      @(posedge clk);
      if ((mem_read | mem_write) === 1'b1) begin
        if (cnt >= lat) begin
          cnt <= 0;
          if (mem_write === 1'b1) mem_arr[mem_address] <= mem_writedata;
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cnt <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Grant scoreboard: every rising strobe must match the next expected grant.
  logic          prev_strobe = 1'b0;
  logic [AW-1:0] held_addr = '0;
  always @(negedge clk) begin
    grant_t e;
    if ((mem_read | mem_write) === 1'b1) begin
      chk1("strobe_exclusive", mem_read & mem_write, 1'b0);
      if (!prev_strobe) begin
        held_addr = mem_address;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got addr %h rd %b wr %b expected none",
                   mem_address, mem_read, mem_write);
        end else begin
          e = exp_q.pop_front();
          chka("grant_addr", mem_address, e.a);
          chk1("grant_rd", mem_read, e.rd);
          chk1("grant_wr", mem_write, e.wr);
          if (e.wr) chk("grant_wdata", mem_writedata, e.wd);
        end
      end else begin
        chka("grant_addr_hold", mem_address, held_addr);
      end
    end
    prev_strobe = ((mem_read | mem_write) === 1'b1);
  end

  task automatic i_txn(input logic [AW-1:0] a);
    bit ok;
    ok = 1'b0;
    i_read = 1'b1;
    i_address = a;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (i_busywait === 1'b0) ok = 1'b1;
    end
    chk1("i_done", ok, 1'b1);
    if (ok) chk("i_rdata", i_readdata, ref_mem[a]);
    @(negedge clk);
    i_read = 1'b0;
  endtask

  task automatic d_txn(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    bit ok;
    ok = 1'b0;
    if (wr) ref_mem[a] = wd;
    d_read = rd;
    d_write = wr;
    d_address = a;
    d_writedata = wd;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (d_busywait === 1'b0) ok = 1'b1;
    end
    chk1("d_done", ok, 1'b1);
    if (ok && rd && !wr) chk("d_rdata", d_readdata, ref_mem[a]);
    @(negedge clk);
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = mkv(1'b1, 6'h02, 1'b1, 1'b0, 6'h10, '0, 4, 1'b1, 1'b1, 1'b0);
    vt[1] = mkv(1'b0, 6'h00, 1'b0, 1'b1, 6'h3F, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_1111,
                2, 1'b1, 1'b0, 1'b1);
    vt[2] = mkv(1'b0, 6'h00, 1'b1, 1'b0, 6'h3F, '0, 3, 1'b1, 1'b1, 1'b0);
    vt[3] = mkv(1'b0, 6'h00, 1'b1, 1'b1, 6'h20, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                1, 1'b1, 1'b0, 1'b1);
    vt[4] = mkv(1'b1, 6'h07, 1'b1, 1'b0, 6'h08, '0, 1, 1'b0, 1'b1, 1'b0);
    vt[5] = mkv(1'b1, 6'h3F, 1'b0, 1'b0, 6'h00, '0, 1, 1'b0, 1'b0, 1'b0);
    vt[6] = mkv(1'b1, 6'h21, 1'b1, 1'b0, 6'h20, '0, 2, 1'b1, 1'b1, 1'b0);

    for (int k = 0; k < 64; k++) ref_mem[k] = pattern(k);

    reset = 1'b0;
    i_read = 1'b1;
    i_address = '0;
    d_read = 1'b0;
    d_write = 1'b0;
    d_address = '0;
    d_writedata = '0;
    lat = 2;

    repeat (3) @(negedge clk);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chka("rst_mem_addr", mem_address, '0);
    chk("rst_mem_wdata", mem_writedata, '0);
    chk1("rst_i_busy_follows_req", i_busywait, 1'b1);
    chk1("rst_d_busy_idle", d_busywait, 1'b0);
    chk("rst_i_rdata", i_readdata, pattern(0));
    chk("rst_d_rdata", d_readdata, pattern(0));
    i_read = 1'b0;
    @(negedge clk);
    chk1("rst_i_busy_dropped", i_busywait, 1'b0);
    reset = 1'b1;

    // Uncontended I-cache read, latency 5.
    @(negedge clk);
    lat = 5;
    exp_q.push_back(mkg(6'h05, 1'b1, 1'b0, '0));
    i_read = 1'b1;
    i_address = 6'h05;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk1("t1_mem_read", mem_read, 1'b1);
        chk1("t1_mem_write", mem_write, 1'b0);
        chka("t1_mem_addr", mem_address, 6'h05);
      end
      chk1("t1_i_busy", i_busywait, (j < 5));
      chk1("t1_d_busy", d_busywait, 1'b0);
      if (j == 5) chk("t1_i_rdata", i_readdata, pattern(5));
    end
    @(negedge clk);
    chk1("t1_strobe_cleared", mem_read, 1'b0);
    i_read = 1'b0;

    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      lat = vt[v].lat;
      if (vt[v].ir && (vt[v].dr || vt[v].dw)) begin
        if (vt[v].d_first) begin
          exp_q.push_back(mkg(vt[v].da, vt[v].exp_drd, vt[v].exp_dwr, vt[v].dwd));
          exp_q.push_back(mkg(vt[v].ia, 1'b1, 1'b0, '0));
        end else begin
          exp_q.push_back(mkg(vt[v].ia, 1'b1, 1'b0, '0));
          exp_q.push_back(mkg(vt[v].da, vt[v].exp_drd, vt[v].exp_dwr, vt[v].dwd));
        end
      end else if (vt[v].ir) begin
        exp_q.push_back(mkg(vt[v].ia, 1'b1, 1'b0, '0));
      end else begin
        exp_q.push_back(mkg(vt[v].da, vt[v].exp_drd, vt[v].exp_dwr, vt[v].dwd));
      end
      fork
        begin
          if (vt[v].ir) i_txn(vt[v].ia);
        end
        begin
          if (vt[v].dr || vt[v].dw) d_txn(vt[v].dr, vt[v].dw, vt[v].da, vt[v].dwd);
        end
      join
      repeat (2) @(negedge clk);
    end

    // Both caches keep requesting: grants alternate D, I, D, I.
    @(negedge clk);
    lat = 3;
    exp_q.push_back(mkg(6'h31, 1'b1, 1'b0, '0));
    exp_q.push_back(mkg(6'h11, 1'b1, 1'b0, '0));
    exp_q.push_back(mkg(6'h32, 1'b1, 1'b0, '0));
    exp_q.push_back(mkg(6'h12, 1'b1, 1'b0, '0));
    fork
      begin
        i_txn(6'h11);
        i_txn(6'h12);
      end
      begin
        d_txn(1'b1, 1'b0, 6'h31, '0);
        d_txn(1'b1, 1'b0, 6'h32, '0);
      end
    join
    chki("alt_queue_drained", exp_q.size(), 0);

    // Reset pulse two cycles into a latency-5 D read; the read is re-granted afterwards.
    repeat (2) @(negedge clk);
    lat = 5;
    exp_q.push_back(mkg(6'h15, 1'b1, 1'b0, '0));
    exp_q.push_back(mkg(6'h15, 1'b1, 1'b0, '0));
    d_read = 1'b1;
    d_write = 1'b0;
    d_address = 6'h15;
    @(negedge clk);
    chk1("rm_strobe_up", mem_read, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("rm_busy_in_reset", d_busywait, 1'b1);
    @(negedge clk);
    chk1("rm_read_cleared", mem_read, 1'b0);
    chk1("rm_write_cleared", mem_write, 1'b0);
    chka("rm_addr_cleared", mem_address, '0);
    chk1("rm_busy_after_reset", d_busywait, 1'b1);
    reset = 1'b1;
    d_txn(1'b1, 1'b0, 6'h15, '0);

    repeat (3) @(negedge clk);
    chki("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single block-organised main memory between the instruction cache and the data cache. Each cache sees a private read/write port with the usual busywait handshake. The arbiter serialises their miss and write-back traffic onto one memory port, with round-robin fairness on simultaneous requests. It sits between `ins_cache`/`data_cache` and a unified main memory at the test-bench level.

## Interface
Parameters:
- `ADDR_W`, 6: block address width.
- `DATA_W`, 128: block width (four 32-bit words).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_read`  in  1  I-cache block read request, held until `i_busywait` is low at an edge.
- `i_address`  in  ADDR_W  I-cache block address.
- `i_readdata`  out  DATA_W  block returned to the I-cache.
- `i_busywait`  out  1  I-cache stall.
- `d_read`, `d_write`  in  1  D-cache block read / write-back request.
- `d_address`  in  ADDR_W  D-cache block address.
- `d_writedata`  in  DATA_W  write-back block.
- `d_readdata`  out  DATA_W  block returned to the D-cache.
- `d_busywait`  out  1  D-cache stall.
- `mem_read`, `mem_write`  out  1  main-memory strobes.
- `mem_address`  out  ADDR_W  main-memory block address.
- `mem_writedata`  out  DATA_W  main-memory write data.
- `mem_readdata`  in  DATA_W  main-memory read data.
- `mem_busywait`  in  1  main-memory busy.

## Operation
- FSM states: `IDLE`, `GRANT_I`, `GRANT_D`.
- Register `last` records the most recent winner. Its reset value is `I`, so the D-cache wins the first tie.
- In `IDLE`, the FSM samples requests at each edge:
  - Only `i_read` asserted: go to `GRANT_I`.
  - Only `d_read` or `d_write` asserted: go to `GRANT_D`.
  - Both caches requesting: grant the requester that is not `last`.
  - On a grant, update `last` and register `mem_address`, `mem_writedata`, `mem_read` and `mem_write` from the winner.
- If `d_read` and `d_write` are both asserted, `d_write` wins and `mem_read` stays 0.
- In `GRANT_x`, the strobes are held stable.
- Completion is the first edge in `GRANT_x` where `mem_busywait` is 0, excluding the grant's first cycle. On completion:
  - return to `IDLE`;
  - clear `mem_read` and `mem_write` at that same edge.
- Requests are never pre-empted. A grant lasts until completion.
- `i_readdata` and `d_readdata` are wired combinationally to `mem_readdata`. Each requester samples its data at the edge where its busywait is low.
- `x_busywait` is combinational: asserted whenever x requests, except in the completion cycle of x's own grant. In that cycle it is 0, which is the cycle where the FSM is in `GRANT_x` past its first cycle and `mem_busywait` is 0.
- Reset (`reset`=0 at an edge):
  - FSM goes to `IDLE`, `last` = `I`.
  - `mem_read`, `mem_write`, `mem_address` and `mem_writedata` are cleared to 0.
  - An in-flight memory transaction is abandoned without completion. The requester keeps stalling until it is re-granted after reset.

## Timing
- Reset values: `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0.
- `x_busywait` follows its request during and after reset. `x_readdata` follows `mem_readdata`.
- Uncontended latency:
  - request seen at edge t;
  - `mem_*` valid from t+1;
  - with a memory that holds busywait for N cycles after the strobe, completion falls at edge t+1+N;
  - the requester unstalls in the cycle before that edge.
- Back-to-back traffic passes through at least one `IDLE` edge. A new grant's strobes appear no earlier than one cycle after the previous completion.
- When both caches keep requesting, grants strictly alternate. Neither waits more than one foreign transaction.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (`IDLE`/`GRANT_I`/`GRANT_D`);
  - the requester id constants (`REQ_I`, `REQ_D`);
  - default `ADDR_W`/`DATA_W`.
- Sub-module `rr_pick2` is the natural split. It is a 2-way round-robin chooser with inputs `req[1:0]` and `last`, output `winner`.
- Top-level integration: the caches' memory ports connect here, and the existing memory models attach to the `mem_*` side.

## Test plan
- I-cache only, `i_read`=1, `i_address`=6'h05, memory latency N=5:
  - `mem_read`=1 with `mem_address`=6'h05 from t+1;
  - `i_busywait` low for exactly one cycle before edge t+6;
  - `i_readdata` = the preloaded block;
  - `d_busywait` stays 0.
- Simultaneous `i_read`@6'h02 and `d_read`@6'h10 out of reset:
  - D is granted first and `i_busywait` stays high throughout;
  - after D completes there is one `IDLE` edge, then I is granted at 6'h02.
- Continuous dual requests for 4 transactions: grant order is D, I, D, I.
- `d_write` @6'h3F with `d_writedata`=128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_1111:
  - `mem_write`=1 and `mem_read`=0;
  - a following `d_read` @6'h3F returns the identical block.
- `d_read`=1 and `d_write`=1 together: only `mem_write` is asserted.
- Reset driven low for one edge mid-grant, 2 cycles into N=5:
  - strobes drop to 0 the next cycle and the FSM is in `IDLE`;
  - the still-requesting cache is re-granted with fresh strobes and completes normally.
